sw_input_port: RTL and testbench

SW_INPUT_PORT -- requirements
Module: sw_input_port

---
 rtl/sw_input_port_pkg.sv | 15 +
 rtl/sw_input_port_if.sv | 27 ++
 rtl/sw_input_port_sync2.sv | 22 ++
 rtl/sw_input_port.sv | 108 ++++++++++
 tb/tb_sw_input_port.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/sw_input_port_pkg.sv
// Shared CPU-side types and constants for the switch input port.
// The enter-key debounce FSM state lives here so software models and RTL agree.
package sw_input_port_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } sw_state_t;

  localparam int SW_W   = 9;
  localparam int KEY_IX = 8;

endpackage

// File: rtl/sw_input_port_if.sv
// Board-switch and CPU read bus for the switch input port.
// master drives switches/read strobe; dut owns the registered data/status.
interface sw_input_port_if #(
  parameter int n = 8
);
  logic [8:0]   sw;
  logic         rd;
  logic [n-1:0] data;
  logic         valid;
  logic         overrun;

  modport master (
    output sw,
    output rd,
    input  data,
    input  valid,
    input  overrun
  );

  modport dut (
    input  sw,
    input  rd,
    output data,
    output valid,
    output overrun
  );
endinterface

// File: rtl/sw_input_port_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
// Latency 2 cycles; no backpressure, samples every clock.
module sync2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/sw_input_port.sv
// Debounced switch capture port: enter key latches sw[7:0] for the CPU to read.
// Latency DEBOUNCE_CYCLES+2 edges from press to valid; no backpressure, unread captures flag overrun.
module sw_input_port
  import sw_input_port_pkg::*;
#(
  parameter int n               = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          n_reset,
  sw_input_port_if.dut  bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync_sw;
  logic             key;
  sw_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_done;
  logic             capture;
  logic [n-1:0]     data_q;
  logic             valid_q;
  logic             ovr_q;

  sync2 #(.WIDTH(SW_W)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (bus.sw),
    .q       (sync_sw)
  );

  assign key = sync_sw[KEY_IX];

  // Counter holds at LAST so a long stable level can never wrap it.
  assign cnt_inc  = (cnt >= LAST) ? cnt : cnt + 1'b1;
  assign cnt_done = (cnt_inc >= LAST);
  assign capture  = (state == DB_PRESS) && key && cnt_done;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (key) state <= DB_PRESS;
        end
        DB_PRESS: begin
          if (!key) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          cnt <= '0;
          if (!key) state <= DB_RELEASE;
        end
        DB_RELEASE: begin
          if (key) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_done) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A read on the capture edge frees the slot, so the new value is taken, not flagged.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (capture) begin
      if (!valid_q || bus.rd) begin
        data_q  <= n'(sync_sw[7:0]);
        valid_q <= 1'b1;
        if (bus.rd) ovr_q <= 1'b0;
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (bus.rd && valid_q) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_sw_input_port.sv
// Directed bench for sw_input_port with DEBOUNCE_CYCLES=4, n=8.
module tb_sw_input_port;
  import sw_input_port_pkg::*;

  localparam int N  = 8;
  localparam int DB = 4;

  logic clk;
  logic n_reset;
  int   checks;
  int   errors;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_v;

  sw_input_port_if #(.n(N)) bus ();

  sw_input_port #(.n(N), .DEBOUNCE_CYCLES(DB)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_exp(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
      exp_v = 'x;
    end else begin
      exp_v = exp_q.pop_front();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    n_reset   = 1'b0;
    bus.sw    = 9'h000;
    bus.rd    = 1'b0;
    tick(3);
    n_reset = 1'b1;
    tick(1);
    check("rst_data",  32'(bus.data),    32'h0);
    check("rst_valid", 32'(bus.valid),   32'h0);
    check("rst_ovr",   32'(bus.overrun), 32'h0);
    check("rst_state", 32'(dut.state),   32'(IDLE));

    // Clean press: valid must appear on edge DB+2, not before.
    bus.sw = 9'h13C;
    exp_q.push_back(8'd60);
    tick(DB + 1);
    check("press_early_valid", 32'(bus.valid), 32'h0);
    tick(1);
    pop_exp("press_pop");
    check("press_valid", 32'(bus.valid), 32'h1);
    check("press_data",  32'(bus.data),  32'(exp_v));
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    check("read_valid", 32'(bus.valid), 32'h0);
    check("read_data",  32'(bus.data),  32'd60);
    bus.sw = 9'h000;
    tick(8);
    check("release_state", 32'(dut.state), 32'(IDLE));
    check("release_valid", 32'(bus.valid), 32'h0);

    // Bounce: 2 high, 1 low, 2 high never reaches DB stable samples.
    bus.sw = 9'h155; tick(2);
    bus.sw = 9'h055; tick(1);
    bus.sw = 9'h155; tick(2);
    bus.sw = 9'h055; tick(10);
    check("bounce_valid", 32'(bus.valid),   32'h0);
    check("bounce_state", 32'(dut.state),   32'(IDLE));
    check("bounce_data",  32'(bus.data),    32'd60);

    // Overrun: second capture while valid keeps the first value.
    bus.sw = 9'h136;
    exp_q.push_back(8'd54);
    tick(DB + 2);
    check("ovr_first_valid", 32'(bus.valid), 32'h1);
    bus.sw = 9'h036; tick(8);
    bus.sw = 9'h172; tick(DB + 2);
    pop_exp("ovr_pop");
    check("ovr_data",  32'(bus.data),    32'(exp_v));
    check("ovr_flag",  32'(bus.overrun), 32'h1);
    check("ovr_valid", 32'(bus.valid),   32'h1);
    bus.sw = 9'h072; tick(8);
    check("ovr_sticky", 32'(bus.overrun), 32'h1);
    bus.rd = 1'b1; tick(1); bus.rd = 1'b0;
    check("ovr_rd_valid", 32'(bus.valid),   32'h0);
    check("ovr_rd_flag",  32'(bus.overrun), 32'h0);
    check("ovr_rd_data",  32'(bus.data),    32'd54);

    // rd with nothing pending must be harmless.
    bus.rd = 1'b1; tick(1); bus.rd = 1'b0;
    check("idle_rd_valid", 32'(bus.valid), 32'h0);
    check("idle_rd_data",  32'(bus.data),  32'd54);

    // Simultaneous read and capture: new value lands, valid stays.
    bus.sw = 9'h111;
    tick(DB + 2);
    check("sim_first_data", 32'(bus.data), 32'h11);
    bus.sw = 9'h011; tick(8);
    bus.sw = 9'h141;
    exp_q.push_back(8'd65);
    tick(DB + 1);
    bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    pop_exp("sim_pop");
    check("sim_data",  32'(bus.data),    32'(exp_v));
    check("sim_valid", 32'(bus.valid),   32'h1);
    check("sim_ovr",   32'(bus.overrun), 32'h0);
    bus.rd = 1'b1; tick(1); bus.rd = 1'b0;
    check("sim_rd_valid", 32'(bus.valid), 32'h0);
    bus.sw = 9'h041; tick(8);

    // Reset mid-press: async clear, then the held key is a fresh press.
    bus.sw = 9'h1AA;
    tick(4);
    check("mid_state_dbp", 32'(dut.state), 32'(DB_PRESS));
    n_reset = 1'b0;
    #2;
    check("async_data",  32'(bus.data),    32'h0);
    check("async_valid", 32'(bus.valid),   32'h0);
    check("async_ovr",   32'(bus.overrun), 32'h0);
    check("async_state", 32'(dut.state),   32'(IDLE));
    tick(2);
    n_reset = 1'b1;
    exp_q.push_back(8'hAA);
    tick(DB + 1);
    check("post_rst_early", 32'(bus.valid), 32'h0);
    tick(1);
    pop_exp("post_rst_pop");
    check("post_rst_valid", 32'(bus.valid), 32'h1);
    check("post_rst_data",  32'(bus.data),  32'(exp_v));
    bus.sw = 9'h000; tick(8);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
